// File: rtl/cdc_pkg.sv
// Shared types and constants for the destination half of the req/ack CDC handshake.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VALID  = 2'd1,
    ACK_HI = 2'd2
  } cdc_rx_state_e;

  localparam int CDC_SYNC_STAGES_DEF = 2;
  localparam int CDC_SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/cdc_handshake_rx_if.sv
// Bundle of source-side req/ack/data and consumer-side valid/ready signals.
interface cdc_handshake_rx_if #(
  parameter int DATA_W = 8
);
  logic              i_req;
  logic [DATA_W-1:0] i_data;
  logic              o_ack;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
  logic              o_busy;

  modport slave (
    input  i_req, i_data, i_ready,
    output o_ack, o_valid, o_data, o_busy
  );

  modport master (
    output i_req, i_data, i_ready,
    input  o_ack, o_valid, o_data, o_busy
  );
endinterface

// File: rtl/sync_ff_chain.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
module sync_ff_chain #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_p <= {STAGES{RESET_VAL}};
    end else begin
      sync_p <= {sync_p[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_p[STAGES-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// Destination-side four-phase handshake receiver; define CDC_RX_EARLY_ACK_EN to
// acknowledge on capture instead of on consumer acceptance.
module cdc_handshake_rx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cdc_handshake_rx_if.slave    bus
);

  localparam int SYNC_N = (SYNC_STAGES < CDC_SYNC_STAGES_MIN) ? CDC_SYNC_STAGES_MIN : SYNC_STAGES;

  cdc_rx_state_e     state_q, state_d;
  logic              valid_q, valid_d;
  logic              ack_q,   ack_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              req_s;

  sync_ff_chain #(
    .STAGES    (SYNC_N),
    .RESET_VAL (1'b0)
  ) u_req_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (bus.i_req),
    .o_q   (req_s)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  // i_data is sampled unsynchronized: the source holds it stable until it sees o_ack.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    data_d  = data_q;
`ifdef CDC_RX_EARLY_ACK_EN
    if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (req_s && (!valid_q || bus.i_ready)) begin
          data_d  = bus.i_data;
          valid_d = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`else
    case (state_q)
      IDLE: begin
        if (req_s) begin
          data_d  = bus.i_data;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (valid_q && bus.i_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`endif
  end

  assign bus.o_ack   = ack_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Bench: two receivers (2- and 3-stage sync) on shared stimulus, checked against a rule-level model.
module tb_cdc_handshake_rx;

`ifdef CDC_RX_EARLY_ACK_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req;
  logic [7:0] data;
  logic       ready;
  logic       rand_rdy;
  logic       sb_en;

  logic [1:0] ack;
  logic [1:0] valid;
  logic [1:0] busy;
  logic [7:0] odat [2];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", nm, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int S = g + 2;

    cdc_handshake_rx_if #(.DATA_W(8)) bus ();

    assign bus.i_req   = req;
    assign bus.i_data  = data;
    assign bus.i_ready = ready;

    cdc_handshake_rx #(
      .DATA_W      (8),
      .SYNC_STAGES (S)
    ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
    );

    assign ack[g]   = bus.o_ack;
    assign valid[g] = bus.o_valid;
    assign busy[g]  = bus.o_busy;
    assign odat[g]  = bus.o_data;

    // Model: req is seen S edges after it is sampled; a word is held until taken,
    // ack follows acceptance (or capture when early) and drops once req is seen low.
    logic [3:0] hist;
    logic       mv, ma;
    logic [7:0] md;
    int         acc_cnt = 0;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        hist <= '0;
        mv   <= 1'b0;
        ma   <= 1'b0;
        md   <= '0;
      end else begin
        hist <= {hist[2:0], req};
`ifdef CDC_RX_EARLY_ACK_EN
        if (mv && ready) mv <= 1'b0;
        if (ma) begin
          if (!hist[S-1]) ma <= 1'b0;
        end else if (hist[S-1] && (!mv || ready)) begin
          ma <= 1'b1;
          mv <= 1'b1;
          md <= data;
        end
`else
        if (ma) begin
          if (!hist[S-1]) ma <= 1'b0;
        end else if (mv) begin
          if (ready) begin
            mv <= 1'b0;
            ma <= 1'b1;
          end
        end else if (hist[S-1]) begin
          mv <= 1'b1;
          md <= data;
        end
`endif
      end
    end

    always @(negedge clk) begin
      check("model_valid", g, 32'(valid[g]), 32'(mv));
      check("model_ack",   g, 32'(ack[g]),   32'(ma));
      check("model_data",  g, 32'(odat[g]),  32'(md));
`ifdef CDC_RX_EARLY_ACK_EN
      check("model_busy",  g, 32'(busy[g]),  32'(ma));
`else
      check("model_busy",  g, 32'(busy[g]),  32'(mv | ma));
`endif
    end

    always @(posedge clk) begin
      if (sb_en && !rst && valid[g] && ready) begin
        check("sb_order", g, 32'(odat[g]), 32'(acc_cnt));
        acc_cnt <= acc_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ack(input logic lvl, input string nm);
    int n = 0;
    while ((ack != {2{lvl}}) && (n < 200)) begin
      tick();
      n++;
    end
    check(nm, 0, 32'(ack), 32'({2{lvl}}));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (((ack | valid | busy) != 2'b00) && (n < 200)) begin
      tick();
      n++;
    end
    check(nm, 0, 32'({ack, valid, busy}), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    req      = 1'b0;
    data     = 8'h00;
    ready    = 1'b0;
    rand_rdy = 1'b0;
    sb_en    = 1'b0;

    // Reset state
    #3;
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", k, 32'(valid[k]), 32'd0);
      check("rst_ack",   k, 32'(ack[k]),   32'd0);
      check("rst_busy",  k, 32'(busy[k]),  32'd0);
      check("rst_data",  k, 32'(odat[k]),  32'd0);
    end
    ticks(2);
    rst = 1'b0;

    // Idle with no request
    for (int i = 0; i < 20; i++) begin
      tick();
      check("s1_idle", 0, 32'({ack, valid, busy}), 32'd0);
    end

    // Basic transfer, consumer always ready
    data  = 8'hA5;
    ready = 1'b1;
    req   = 1'b1;
    ticks(2);
    check("s2_valid_e12", 0, 32'(valid[0]), 32'd0);
    tick();
    check("s2_valid_e13", 0, 32'(valid[0]), 32'd1);
    check("s2_data_e13",  0, 32'(odat[0]),  32'hA5);
    check("s2_ack_e13",   0, 32'(ack[0]),   32'(EARLY));
    check("s2_valid_e13", 1, 32'(valid[1]), 32'd0);
    tick();
    check("s2_ack_e14",   0, 32'(ack[0]),   32'd1);
    check("s2_valid_e14", 0, 32'(valid[0]), 32'd0);
    check("s2_valid_e14", 1, 32'(valid[1]), 32'd1);
    check("s2_data_e14",  1, 32'(odat[1]),  32'hA5);
    tick();
    check("s2_ack_e15",   1, 32'(ack[1]),   32'd1);
    ticks(5);
    req = 1'b0;
    ticks(2);
    check("s2_ack_e22", 0, 32'(ack[0]), 32'd1);
    tick();
    check("s2_ack_e23",  0, 32'(ack[0]),  32'd0);
    check("s2_busy_e23", 0, 32'(busy[0]), 32'd0);
    check("s2_ack_e23",  1, 32'(ack[1]),  32'd1);
    tick();
    check("s2_ack_e24",  1, 32'(ack[1]),  32'd0);
    wait_idle("s2_idle");

    // Consumer stall; data changes while the word is held
    data  = 8'h5A;
    ready = 1'b0;
    req   = 1'b1;
    ticks(3);
    check("s3_valid_e13", 0, 32'(valid[0]), 32'd1);
    check("s3_data_e13",  0, 32'(odat[0]),  32'h5A);
    check("s3_ack_e13",   0, 32'(ack[0]),   32'(EARLY));
    tick();
    check("s3_valid_e14", 1, 32'(valid[1]), 32'd1);
    data = 8'hFF;
    ticks(16);
    check("s3_hold_valid", 0, 32'(valid[0]), 32'd1);
    check("s3_hold_data",  0, 32'(odat[0]),  32'h5A);
    check("s3_hold_data",  1, 32'(odat[1]),  32'h5A);
    check("s3_hold_ack",   0, 32'(ack[0]),   32'(EARLY));
    ready = 1'b1;
    tick();
    check("s3_ack_e31",   0, 32'(ack[0]),   32'd1);
    check("s3_valid_e31", 0, 32'(valid[0]), 32'd0);
    check("s3_ack_e31",   1, 32'(ack[1]),   32'd1);
    req = 1'b0;
    wait_idle("s3_idle");

    // Sixteen four-phase transfers with a random consumer
    sb_en    = 1'b1;
    rand_rdy = 1'b1;
    for (int w = 0; w < 16; w++) begin
      data = 8'(w);
      req  = 1'b1;
      wait_ack(1'b1, "s4_ack_hi");
      req = 1'b0;
      wait_ack(1'b0, "s4_ack_lo");
    end
    rand_rdy = 1'b0;
    ready    = 1'b1;
    wait_idle("s4_idle");
    sb_en = 1'b0;
    check("s4_count", 0, 32'(g_inst[0].acc_cnt), 32'd16);
    check("s4_count", 1, 32'(g_inst[1].acc_cnt), 32'd16);

    // Reset mid-transfer, request still high afterwards
    ready = 1'b0;
    data  = 8'h3C;
    req   = 1'b1;
    ticks(4);
    check("s5_valid_pre", 0, 32'(valid), 32'd3);
    check("s5_data_pre",  0, 32'(odat[0]), 32'h3C);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("s5_async", k, 32'({ack[k], valid[k], busy[k], odat[k]}), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ticks(2);
    check("s5_valid_r2", 0, 32'(valid[0]), 32'd0);
    tick();
    check("s5_valid_r3", 0, 32'(valid[0]), 32'd1);
    check("s5_data_r3",  0, 32'(odat[0]),  32'h3C);
    check("s5_valid_r3", 1, 32'(valid[1]), 32'd0);
    tick();
    check("s5_valid_r4", 1, 32'(valid[1]), 32'd1);
    check("s5_data_r4",  1, 32'(odat[1]),  32'h3C);
    ready = 1'b1;
    wait_ack(1'b1, "s5_ack_hi");
    req = 1'b0;
    wait_idle("s5_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
